amba_arbiter: RTL

// - Round-robin AHB bus arbiter: shares the single AHB address/data path between NMASTERS masters.
// - Drives hgrant to the masters and hmaster to the master-side address/data mux.
// - The address decoder downstream sees only the winning master's haddr.
// - Parks the bus on DEFAULT_MASTER when no master requests.

---
 rtl/amba_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/amba_arbiter.sv
// amba_arbiter
//   Round-robin AHB bus arbiter. It shares one AHB address/data path between
//   NMASTERS masters and parks the bus on DEFAULT_MASTER when nobody requests.
//
//   Optional feature: define AMBA_ARB_LOCK_EN to honour hlock. A master that
//   wins with hlock=1 keeps the bus until it drops hlock. Without the macro,
//   hlock is ignored and hmaster_lock stays 0.
//
// Ports
//   hclk          in   clock
//   hreset        in   synchronous reset, active-high
//   hbusreq       in   [NMASTERS]  bus request per master
//   hlock         in   [NMASTERS]  locked-transfer request per master
//   htrans        in   [2]         htrans of the muxed master (00 IDLE)
//   hready        in   bus ready; when low, every register holds
//   hgrant        out  [NMASTERS]  one-hot registered grant
//   hmaster       out  [MWIDTH]    address-phase owner, drives the master mux
//   hmaster_lock  out  current address phase is locked
//
// States
//   state  | meaning
//   PARK   | no requester, grant parked on DEFAULT_MASTER
//   OWNED  | grant held by a requesting master
//   LOCKED | grant frozen for a locked sequence (AMBA_ARB_LOCK_EN only)

module amba_arbiter #(
  parameter int NMASTERS       = 4,
  parameter int DEFAULT_MASTER = 0,
  localparam int MWIDTH        = $clog2(NMASTERS)
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic [NMASTERS-1:0] hbusreq,
  input  logic [NMASTERS-1:0] hlock,
  input  logic [1:0]          htrans,
  input  logic                hready,
  output logic [NMASTERS-1:0] hgrant,
  output logic [MWIDTH-1:0]   hmaster,
  output logic                hmaster_lock
);

`ifdef AMBA_ARB_LOCK_EN
  typedef enum logic [1:0] {PARK, OWNED, LOCKED} state_t;
  localparam logic LOCK_EN = 1'b1;
`else
  typedef enum logic {PARK, OWNED} state_t;
  localparam logic LOCK_EN = 1'b0;
`endif

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  state_t              state, state_nxt;
  logic [NMASTERS-1:0] hgrant_nxt;
  logic [MWIDTH-1:0]   owner;
  logic [MWIDTH-1:0]   winner;
  logic [MWIDTH-1:0]   idx;
  logic                found;
  logic                locked;
  logic                arb_point;

  // Owner is the index of the set grant bit; it doubles as the rotation pointer.
  always_comb begin
    owner = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (hgrant[i]) owner = MWIDTH'(i);
    end
  end

  // Search owner+1, owner+2, ... wrapping, ending at owner itself, so a sole
  // requester that already owns the bus wins again.
  always_comb begin
    found  = 1'b0;
    winner = MWIDTH'(DEFAULT_MASTER);
    idx    = '0;
    for (int i = 1; i <= NMASTERS; i++) begin
      idx = MWIDTH'((int'(owner) + i) % NMASTERS);
      if (!found && hbusreq[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    hgrant_nxt = hgrant;
    locked     = 1'b0;
`ifdef AMBA_ARB_LOCK_EN
    locked     = (state == LOCKED);
`endif
    arb_point  = !locked && ((state == PARK) || !hbusreq[owner] || (htrans == HTRANS_IDLE));

    if (hready) begin
      if (locked) begin
`ifdef AMBA_ARB_LOCK_EN
        // Grant held on the exit edge; normal arbitration resumes next cycle.
        if (!hlock[owner]) state_nxt = hbusreq[owner] ? OWNED : PARK;
`endif
      end else if (arb_point) begin
        hgrant_nxt = '0;
        if (found) begin
          hgrant_nxt[winner] = 1'b1;
          state_nxt          = OWNED;
`ifdef AMBA_ARB_LOCK_EN
          if (hlock[winner]) state_nxt = LOCKED;
`endif
        end else begin
          hgrant_nxt[DEFAULT_MASTER] = 1'b1;
          state_nxt                  = PARK;
        end
      end
`ifdef AMBA_ARB_LOCK_EN
      // Owner continuing a burst raises hlock: freeze from here on.
      else if (hlock[owner] && (htrans != HTRANS_IDLE)) begin
        state_nxt = LOCKED;
      end
`endif
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state                  <= PARK;
      hgrant                 <= '0;
      hgrant[DEFAULT_MASTER] <= 1'b1;
      hmaster                <= MWIDTH'(DEFAULT_MASTER);
      hmaster_lock           <= 1'b0;
    end else if (hready) begin
      state        <= state_nxt;
      hgrant       <= hgrant_nxt;
      // Address phase follows the grant by one hready cycle.
      hmaster      <= owner;
      hmaster_lock <= hlock[owner] & LOCK_EN;
    end
  end

endmodule
